// File: rtl/ifetch_queue_if.sv
// Handshake bundle between the instruction prefetch queue, instruction memory,
// the IR load path and the redirect source in control.
interface ifetch_queue_if;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_take;
    logic [15:0] instr_word;
    logic [15:0] instr_pc;

    modport master (
        input  redirect, redirect_pc, mem_resp, mem_rdata, instr_take,
        output mem_address, mem_read, instr_valid, instr_word, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_resp, mem_rdata, instr_take,
        input  mem_address, mem_read, instr_valid, instr_word, instr_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches words ahead of the IR, tags each with its PC.
// Optional IFETCH_PERF_EN adds saturating fetch and starvation counters.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_queue_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]   perf_fetches,
    output logic [15:0]   perf_stalls
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_fetch_pc;
    logic [15:0]   w_fetch_pc_nxt;
    logic [15:0]   r_req_addr;
    logic [15:0]   w_req_addr_nxt;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_post;
    logic [15:0]   r_pc_q   [DEPTH];
    logic [15:0]   r_word_q [DEPTH];
    logic          w_take;
    logic          w_wr;
    logic          w_not_full;
    logic [15:0]   w_redirect_pc;

    // Redirect wins over both the pop and the push in its cycle.
    assign w_redirect_pc = bus.redirect_pc & 16'hFFFE;
    assign w_take        = bus.instr_take && (r_count != '0) && !bus.redirect;
    assign w_wr          = (r_state == S_FETCH) && bus.mem_resp && !bus.redirect;
    assign w_count_post  = r_count + CW'(w_wr) - CW'(w_take);
    assign w_not_full    = (r_count < CW'(DEPTH));

    assign bus.mem_read    = (r_state != S_IDLE);
    assign bus.mem_address = r_req_addr;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr_word  = r_word_q[r_head];
    assign bus.instr_pc    = r_pc_q[r_head];

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;

        if (bus.redirect) begin
            w_fetch_pc_nxt = w_redirect_pc;
        end

        case (r_state)
            S_IDLE: begin
                if (!bus.redirect && w_not_full) begin
                    w_req_addr_nxt = r_fetch_pc;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    w_state_nxt = bus.mem_resp ? S_IDLE : S_DISCARD;
                end else if (bus.mem_resp) begin
                    w_fetch_pc_nxt = r_req_addr + 16'd2;
                    // Chain the next request only if the word just written leaves room.
                    if (w_count_post < CW'(DEPTH)) begin
                        w_req_addr_nxt = r_req_addr + 16'd2;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (bus.mem_resp) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            if (bus.redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_wr) begin
                    r_tail <= r_tail + AW'(1);
                end
                if (w_take) begin
                    r_head <= r_head + AW'(1);
                end
                r_count <= w_count_post;
            end
        end
    end

    // Entry payload needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_pc_q[r_tail]   <= r_req_addr;
            r_word_q[r_tail] <= bus.mem_rdata;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] r_perf_fetches;
    logic [15:0] r_perf_stalls;
    logic        w_starved;

    assign w_starved    = (r_count == '0) && (r_state != S_IDLE);
    assign perf_fetches = r_perf_fetches;
    assign perf_stalls  = r_perf_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetches <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_wr && (r_perf_fetches != 16'hFFFF)) begin
                r_perf_fetches <= r_perf_fetches + 16'd1;
            end
            if (w_starved && (r_perf_stalls != 16'hFFFF)) begin
                r_perf_stalls <= r_perf_stalls + 16'd1;
            end
        end
    end
`endif

endmodule
